// File: rtl/key_generator_if.sv
// Bus between the S-box generator / encryption datapath and the round-key expander.
// valid/done_key are one-cycle qualifiers with no ready: the consumer must take key in the cycle valid is high.
interface key_generator_if #(
  parameter int V_SIZE   = 8,
  parameter int KEY_SIZE = 128
);
  logic [KEY_SIZE-1:0] initial_key;
  logic                sbox_valid;
  logic [V_SIZE-1:0]   V_out;
  logic                sbox_done;
  logic                valid;
  logic [KEY_SIZE-1:0] key;
  logic                done_key;
  logic                dbg_state;

  modport master (
    output initial_key, sbox_valid, V_out, sbox_done,
    input  valid, key, done_key, dbg_state
  );

  modport slave (
    input  initial_key, sbox_valid, V_out, sbox_done,
    output valid, key, done_key, dbg_state
  );
endinterface

// File: rtl/key_generator.sv
// Round-key expander: captures a streamed S-box, then expands initial_key into ROUND keys
// with an AES-like SubWord / rotate-by-one-symbol / XOR / rcon step, one key per cycle.
module key_generator #(
  parameter int V_SIZE   = 8,
  parameter int KEY_SIZE = 128,
  parameter int ROUND    = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  key_generator_if.slave io
);
  localparam int DEPTH = 2 ** V_SIZE;
  localparam int N     = KEY_SIZE / V_SIZE;
  localparam int RW    = $clog2(ROUND + 2);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;

  logic [0:0]          r_state;
  logic [V_SIZE-1:0]   r_sbox [DEPTH];
  logic [V_SIZE-1:0]   r_wr_ptr;
  logic [RW-1:0]       r_round;
  logic [KEY_SIZE-1:0] r_work;
  logic [KEY_SIZE-1:0] r_key;
  logic                r_valid;
  logic                r_done_key;

  logic                w_wr_en;
  logic [V_SIZE-1:0]   w_rcon;
  logic [V_SIZE-1:0]   w_sym [N];
  logic [V_SIZE-1:0]   w_sub [N];
  logic [KEY_SIZE-1:0] w_next;

  // The table only accepts entries while idle; it is frozen for the whole expansion.
  assign w_wr_en = (r_state == S_IDLE) && io.sbox_valid;
  assign w_rcon  = V_SIZE'(1) << (r_round - RW'(1));

  // Symbol 0 is the most significant; the substituted word is rotated left by one symbol.
  for (genvar g = 0; g < N; g++) begin : g_sym
    assign w_sym[g] = r_work[KEY_SIZE-1-g*V_SIZE -: V_SIZE];
    assign w_sub[g] = r_sbox[w_sym[g]];
    if (g == 0) begin : g_rc
      assign w_next[KEY_SIZE-1 -: V_SIZE] = w_sub[(g+1)%N] ^ w_sym[g] ^ w_rcon;
    end else begin : g_norc
      assign w_next[KEY_SIZE-1-g*V_SIZE -: V_SIZE] = w_sub[(g+1)%N] ^ w_sym[g];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_sbox[i] <= '0;
    end else if (w_wr_en) begin
      r_sbox[r_wr_ptr] <= io.V_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_round    <= '0;
      r_work     <= '0;
      r_key      <= '0;
      r_valid    <= 1'b0;
      r_done_key <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_done_key <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io.sbox_valid) r_wr_ptr <= r_wr_ptr + V_SIZE'(1);
          if (io.sbox_done) begin
            r_work  <= io.initial_key;
            r_round <= RW'(1);
            r_state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_key   <= w_next;
          r_work  <= w_next;
          r_valid <= 1'b1;
          r_round <= r_round + RW'(1);
          // Next load after expansion starts the table from entry 0 again.
          if (r_round == RW'(ROUND)) begin
            r_done_key <= 1'b1;
            r_wr_ptr   <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.valid     = r_valid;
  assign io.key       = r_key;
  assign io.done_key  = r_done_key;
  assign io.dbg_state = r_state;
endmodule

// File: tb/tb_key_generator.sv
// Scoreboard bench for key_generator: a transaction-level model predicts round keys into a queue,
// a negedge monitor pops and compares whenever the DUT asserts valid.
module tb_key_generator;
  localparam int V_SIZE   = 8;
  localparam int KEY_SIZE = 128;
  localparam int ROUND    = 5;
  localparam int N        = KEY_SIZE / V_SIZE;
  localparam int W        = KEY_SIZE + 1;

  localparam logic [KEY_SIZE-1:0] K_SCEN2  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [KEY_SIZE-1:0] K2_R1    = 128'hDC99DD11DD99DDEE_DD99DD11DD99DDEE;
  localparam logic [KEY_SIZE-1:0] KID_R1   = 128'h0100_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [KEY_SIZE-1:0] KID_R2   = 128'h0300_0000_0000_0000_0000_0000_0000_0001;

  logic clk;
  logic reset_n;

  key_generator_if #(.V_SIZE(V_SIZE), .KEY_SIZE(KEY_SIZE)) bus ();

  key_generator #(.V_SIZE(V_SIZE), .KEY_SIZE(KEY_SIZE), .ROUND(ROUND)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0]        exp_q[$];
  logic [V_SIZE-1:0]   msbox [2**V_SIZE];
  int                  mptr;
  int                  mbusy;
  logic [KEY_SIZE-1:0] mlast;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [KEY_SIZE-1:0] f_model(input logic [KEY_SIZE-1:0] w, input int r);
    logic [V_SIZE-1:0]   b [N];
    logic [KEY_SIZE-1:0] nk;
    logic [V_SIZE-1:0]   rc;
    for (int i = 0; i < N; i++) b[i] = w[KEY_SIZE-1-V_SIZE*i -: V_SIZE];
    rc = V_SIZE'(1 << (r - 1));
    for (int i = 0; i < N; i++)
      nk[KEY_SIZE-1-V_SIZE*i -: V_SIZE] = msbox[b[(i+1)%N]] ^ b[i] ^ ((i == 0) ? rc : '0);
    return nk;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**V_SIZE; i++) msbox[i] = '0;
    mptr  = 0;
    mbusy = 0;
    mlast = '0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour: idle writes/start, or one expansion cycle.
  task automatic model_edge(input logic sv, input logic [V_SIZE-1:0] v, input logic sd,
                            input logic [KEY_SIZE-1:0] k);
    logic [KEY_SIZE-1:0] w;
    if (mbusy == 0) begin
      if (sv) begin
        msbox[mptr] = v;
        mptr = (mptr + 1) % (2**V_SIZE);
      end
      if (sd) begin
        w = k;
        for (int r = 1; r <= ROUND; r++) begin
          w = f_model(w, r);
          exp_q.push_back({(r == ROUND), w});
        end
        mlast = w;
        mbusy = ROUND;
      end
    end else begin
      mbusy--;
      if (mbusy == 0) mptr = 0;
    end
  endtask

  // driver: present inputs for one cycle, then advance the model at that edge
  task automatic step(input logic sv, input logic [V_SIZE-1:0] v, input logic sd,
                      input logic [KEY_SIZE-1:0] k);
    bus.sbox_valid  = sv;
    bus.V_out       = v;
    bus.sbox_done   = sd;
    bus.initial_key = k;
    @(posedge clk);
    model_edge(sv, v, sd, k);
    #1;
    bus.sbox_valid = 1'b0;
    bus.sbox_done  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mbusy != 0 || exp_q.size() != 0) && n < 40) begin
      idle();
      n++;
    end
    idle();
    check({name, "_drained"}, W'(exp_q.size()), W'(0));
    check({name, "_key_hold"}, {1'b0, bus.key}, {1'b0, mlast});
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_valid", W'(bus.valid), W'(0));
    check("reset_done_key", W'(bus.done_key), W'(0));
    check("reset_key", {1'b0, bus.key}, W'(0));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_key(output logic [KEY_SIZE-1:0] k);
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n) begin
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual_key=%h expected=no_key", bus.key);
        end else begin
          e = exp_q.pop_front();
          check("round_key", {bus.done_key, bus.key}, e);
        end
      end else if (bus.done_key) begin
        check("done_without_valid", W'(bus.done_key), W'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_SIZE-1:0] k;
    reset_n         = 1'b0;
    bus.sbox_valid  = 1'b0;
    bus.V_out       = '0;
    bus.sbox_done   = 1'b0;
    bus.initial_key = '0;
    model_clear();

    // 1: reset, outputs stay quiet without stimulus
    do_reset();
    repeat (4) idle();
    check("quiet_valid", W'(bus.valid), W'(0));
    check("quiet_key", {1'b0, bus.key}, W'(0));

    // 2: inverse table, known key
    for (int i = 0; i < 256; i++) step(1'b1, V_SIZE'(255 - i), 1'b0, '0);
    step(1'b0, '0, 1'b1, K_SCEN2);
    idle();
    check("scen2_round1", {bus.valid, bus.key}, {1'b1, K2_R1});
    drain("scen2");

    // 3: identity table, zero key
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, V_SIZE'(i), 1'b0, '0);
    step(1'b0, '0, 1'b1, '0);
    idle();
    check("ident_round1", {1'b0, bus.key}, {1'b0, KID_R1});
    idle();
    check("ident_round2", {1'b0, bus.key}, {1'b0, KID_R2});
    drain("ident");

    // 4: sbox_valid held through start and expansion, second sbox_done while busy
    rand_key(k);
    for (int i = 0; i < 20; i++)
      step(1'b1, V_SIZE'($urandom_range(0, 255)), (i == 5 || i == 7), k);
    drain("held");
    rand_key(k);
    step(1'b0, '0, 1'b1, k);
    drain("held_after");

    // 5: reset after round 2, then reload and rerun scenario 2
    for (int i = 0; i < 256; i++) step(1'b1, V_SIZE'(255 - i), 1'b0, '0);
    step(1'b0, '0, 1'b1, K_SCEN2);
    idle();
    idle();
    @(negedge clk);
    do_reset();
    repeat (3) idle();
    check("abort_quiet", W'(bus.valid), W'(0));
    for (int i = 0; i < 256; i++) step(1'b1, V_SIZE'(255 - i), 1'b0, '0);
    step(1'b0, '0, 1'b1, K_SCEN2);
    idle();
    check("rerun_round1", {bus.valid, bus.key}, {1'b1, K2_R1});
    drain("rerun");

    // 6: wrap with 300 entries, then partial table of 10 entries
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, V_SIZE'($urandom_range(0, 255)), 1'b0, '0);
    rand_key(k);
    step(1'b0, '0, 1'b1, k);
    drain("wrap");
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, V_SIZE'($urandom_range(0, 255)), 1'b0, '0);
    rand_key(k);
    k[KEY_SIZE-1 -: 16] = 16'h0309;
    step(1'b0, '0, 1'b1, k);
    drain("partial");

    // random traffic: writes and starts at arbitrary times
    for (int i = 0; i < 600; i++) begin
      rand_key(k);
      step(1'($urandom_range(0, 1)), V_SIZE'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0), k);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
